// File: rtl/mcp3008_responder.sv
// MCP3008-compatible SPI slave: decodes start/config bits from the master,
// latches the selected 10-bit channel value and shifts it back MSB-first then LSB-first.
`timescale 1ns/1ps
module mcp3008_responder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sclk,
  input  logic        cs_n,
  input  logic        din,
  output logic        dout,
  output logic        dout_oe,
  input  logic [79:0] ch_data,
  output logic        sample_strobe,
  output logic [2:0]  sample_ch,
  output logic        sample_diff,
  output logic        busy
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_WAIT_START, ST_CONFIG, ST_SAMPLE, ST_NULL, ST_MSB, ST_LSB, ST_ZERO
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, din_sync_q, flush_q;
  logic                   sclk_prev_q;
  logic                   sclk_s, cs_s, din_s, sync_ok, rise, fall;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] cfg_q, cfg_d;
  logic [9:0] data_q, data_d;
  logic [9:0] ch_sel;
  logic [2:0] ch_q, ch_d;
  logic       dout_q, dout_d;
  logic       oe_q, oe_d;
  logic       strobe_q, strobe_d;
  logic       diff_q, diff_d;
  logic       busy_q, busy_d;
  logic       arm_q, arm_d;

  assign sclk_s  = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s    = cs_sync_q[SYNC_STAGES-1];
  assign din_s   = din_sync_q[SYNC_STAGES-1];
  // flush_q marks when the chains hold real pad levels rather than reset fill
  assign sync_ok = flush_q[SYNC_STAGES-1];
  assign rise    = sclk_s & ~sclk_prev_q;
  assign fall    = ~sclk_s & sclk_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      din_sync_q  <= '0;
      flush_q     <= '0;
      sclk_prev_q <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
      din_sync_q  <= {din_sync_q[SYNC_STAGES-2:0], din};
      flush_q     <= {flush_q[SYNC_STAGES-2:0], 1'b1};
      sclk_prev_q <= sclk_s;
    end
  end

  always_comb begin
    ch_sel = '0;
    for (int n = 0; n < 8; n++) begin
      if (cfg_q[2:0] == n[2:0]) ch_sel = ch_data[n*10 +: 10];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cfg_d    = cfg_q;
    data_d   = data_q;
    ch_d     = ch_q;
    diff_d   = diff_q;
    dout_d   = dout_q;
    oe_d     = oe_q;
    strobe_d = 1'b0;
    arm_d    = arm_q;
    if (sync_ok && cs_s) arm_d = 1'b1;

    if (cs_s && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      cfg_d   = '0;
      dout_d  = 1'b0;
      oe_d    = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // a frame needs a cs_n high seen after reset before the low is accepted
          if (sync_ok && !cs_s && arm_q) begin
            state_d = ST_WAIT_START;
            arm_d   = 1'b0;
          end
        end
        ST_WAIT_START: begin
          if (rise && din_s) begin
            state_d = ST_CONFIG;
            cnt_d   = '0;
          end
        end
        ST_CONFIG: begin
          if (rise && cnt_q != 4'd4) begin
            cfg_d = {cfg_q[2:0], din_s};
            cnt_d = cnt_q + 4'd1;
          end else if (fall && cnt_q == 4'd4) begin
            data_d   = ch_sel;
            strobe_d = 1'b1;
            ch_d     = cfg_q[2:0];
            diff_d   = ~cfg_q[3];
            oe_d     = 1'b1;
            dout_d   = 1'b0;
            state_d  = ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          if (fall) begin
            state_d = ST_NULL;
            dout_d  = 1'b0;
          end
        end
        ST_NULL: begin
          if (fall) begin
            state_d = ST_MSB;
            cnt_d   = 4'd9;
            dout_d  = data_q[9];
          end
        end
        ST_MSB: begin
          if (fall) begin
            if (cnt_q == 4'd0) begin
              state_d = ST_LSB;
              cnt_d   = 4'd1;
            end else begin
              cnt_d = cnt_q - 4'd1;
            end
            dout_d = data_q[cnt_d];
          end
        end
        ST_LSB: begin
          if (fall) begin
            if (cnt_q == 4'd9) begin
              state_d = ST_ZERO;
              dout_d  = 1'b0;
            end else begin
              cnt_d  = cnt_q + 4'd1;
              dout_d = data_q[cnt_d];
            end
          end
        end
        ST_ZERO:  dout_d = 1'b0;
        default:  state_d = ST_IDLE;
      endcase
    end
    busy_d = !(state_d == ST_IDLE || state_d == ST_WAIT_START);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      cfg_q    <= '0;
      data_q   <= '0;
      ch_q     <= '0;
      diff_q   <= 1'b0;
      dout_q   <= 1'b0;
      oe_q     <= 1'b0;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
      arm_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cfg_q    <= cfg_d;
      data_q   <= data_d;
      ch_q     <= ch_d;
      diff_q   <= diff_d;
      dout_q   <= dout_d;
      oe_q     <= oe_d;
      strobe_q <= strobe_d;
      busy_q   <= busy_d;
      arm_q    <= arm_d;
    end
  end

  assign dout          = dout_q;
  assign dout_oe       = oe_q;
  assign sample_strobe = strobe_q;
  assign sample_ch     = ch_q;
  assign sample_diff   = diff_q;
  assign busy          = busy_q;

endmodule

// File: doc/mcp3008_responder.md
MCP3008_RESPONDER -- requirements
Module: mcp3008_responder

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; all logic runs on clk, and rst_n is applied asynchronously and released synchronously to clk.
REQ-002 Parameter: SYNC_STAGES, default 2, number of synchronizer flops on sclk, cs_n and din (legal values 2..3).
REQ-003 clk  input  1  system clock; SHALL be at least 8x the sclk frequency.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 sclk  input  1  SPI data clock from the ADC master (mcp3008 dclk); asynchronous to clk.
REQ-006 cs_n  input  1  active-low chip select from the master.
REQ-007 din  input  1  configuration bits from the master; sampled on sclk rising edges.
REQ-008 dout  output  1  conversion data to the master; changes only after sclk falling edges.
REQ-009 dout_oe  output  1  high while dout is driven; low means tri-state at the pad.
REQ-010 ch_data  input  80  eight 10-bit channel values; channel n at bits [10n+9:10n].
REQ-011 sample_strobe  output  1  one-clk pulse when a channel value is latched.
REQ-012 sample_ch  output  3  channel selected by the current frame (D2..D0).
REQ-013 sample_diff  output  1  1 = differential request (SGL/DIFF bit 0).
REQ-014 busy  output  1  high from start-bit detection until the frame ends.

Function
REQ-015 sclk, cs_n and din SHALL pass through SYNC_STAGES flops; sclk edges SHALL be detected on the synchronized signal, with total detection latency of at most SYNC_STAGES+1 clk cycles.
REQ-016 States: IDLE, WAIT_START, CONFIG, SAMPLE, NULL, MSB, LSB, ZERO.
REQ-017 IDLE -> WAIT_START when synchronized cs_n goes low.
REQ-018 WAIT_START: on each sclk rise, if din=1 -> CONFIG, busy=1, bit counter=0; leading zeros are ignored.
REQ-019 CONFIG: on each sclk rise, shift din into a 4-bit register {SGL/DIFF, D2, D1, D0}; the 4th rise -> SAMPLE pending.
REQ-020 On the first sclk fall after D0: latch ch_data[sample_ch] into a 10-bit shift register, pulse sample_strobe for one clk, update sample_ch/sample_diff, set dout_oe=1, dout=0, and enter SAMPLE.
REQ-021 Next sclk fall: NULL, dout=0 (null bit).
REQ-022 The next 10 sclk falls: MSB state; dout = B9, B8, ..., B0.
REQ-023 The next 9 sclk falls: LSB state; dout = B1, B2, ..., B9 (B0 not repeated).
REQ-024 Any further sclk falls: ZERO state; dout=0, dout_oe=1.
REQ-025 Differential requests SHALL return ch_data[sample_ch] unchanged; only sample_diff reports the mode.
REQ-026 A synchronized cs_n rise in any state SHALL force IDLE within one clk: dout_oe=0, dout=0, busy=0, bit counter cleared; a partial frame produces no further output.
REQ-027 The latched value SHALL NOT change mid-frame even if ch_data changes.
REQ-028 A new frame SHALL require cs_n high then low; the block SHALL ignore a second start bit within one cs_n-low period.
REQ-029 If sclk rises and falls within the same synchronizer window (clk below the 8x requirement), behaviour is undefined and is not checked.

Reset
REQ-030 While rst_n=0: state=IDLE, dout=0, dout_oe=0, busy=0, sample_strobe=0, sample_ch=0, sample_diff=0, shift and config registers=0, synchronizers=idle levels (sclk 0, cs_n 1, din 0).
REQ-031 Reset asserted mid-frame SHALL abort the frame immediately. After release, the block SHALL wait for a fresh cs_n high-to-low before it accepts a start bit.

Verification
REQ-032 Single-ended frame: ch_data ch3=10'h2A5, din=1,1,0,1,1 then 19 clocks -> one sample_strobe, sample_ch=3, sample_diff=0, dout after null = 1010100101.
REQ-033 Back-to-back frames as an mcp3008 master sends them (CH0 single, then CH2 single), ch0=10'h3FF, ch2=10'h001 -> 32-bit master word low 20 bits equal {3FF,001}-aligned data; two strobes.
REQ-034 Extended clocking: ch5=10'h301, 34 clocks after start -> MSB 1100000001, LSB 000000011, then zeros with dout_oe=1.
REQ-035 cs_n deasserted after 5 data bits -> dout_oe=0 within SYNC_STAGES+2 clk, busy=0; the next full frame returns correct data.
REQ-036 Leading zeros: din=0,0,0,1,0,1,1,1 (diff, ch7) -> sample_diff=1, sample_ch=7, data=ch_data[79:70].
REQ-037 rst_n pulsed low during MSB state -> all outputs at reset values at once. cs_n held low after release -> no response until cs_n toggles.
